// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
//   Multi-cycle control FSM for a RISC-V core with one instruction in flight.
//   Sequences FETCH -> DECODE -> EXEC -> (MEM) -> (WB) and drives every
//   datapath enable and mux select, including the one-hot immediate format
//   select consumed by the immediate generator.
//
//   Optional feature macro: CTRL_TRAP_EN
//     defined   : illegal opcodes and memory timeouts enter a sticky TRAP state.
//     undefined : no TRAP state and no timeout counter; illegal opcodes retire
//                 as a NOP with PC+4, trap_o is tied low.
//
// Parameters
//   MEM_TIMEOUT  cycles mem_req_o may stay unacknowledged before trapping
//                (CTRL_TRAP_EN only); 0 disables the check.
//   TIMEOUT_W    width of the timeout counter; MEM_TIMEOUT < 2**TIMEOUT_W.
//
// Ports
//   clk_i            sole clock, rising edge
//   rst_ni           synchronous active-low reset
//   ins_i[31:0]      instruction register contents
//   branch_cond_i    ALU compare result, valid in EXEC
//   mem_ack_i        memory completion pulse
//   mem_req_o        memory request
//   mem_we_o         store request
//   mem_is_fetch_o   address select: 1 = PC, 0 = ALU result
//   ir_write_o       load instruction register
//   pc_write_o       update PC
//   pc_sel_o[1:0]    0 = PC+4, 1 = PC+imm, 2 = {ALU[31:1],1'b0}
//   imm_sel_o[4:0]   one-hot: 10000 I, 01000 S, 00100 SB, 00010 U, 00001 UJ
//   alu_src_a_o[1:0] 0 = rs1, 1 = PC, 2 = zero
//   alu_src_b_o      0 = rs2, 1 = imm
//   alu_op_o[1:0]    0 = add, 1 = funct-decoded, 2 = branch compare
//   reg_write_o      register file write
//   wb_sel_o[1:0]    0 = ALU, 1 = load data, 2 = PC+4
//   retire_o         one-cycle pulse per completed instruction
//   trap_o           sticky fault flag
//   state_o[2:0]     current state, debug
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned TIMEOUT_W   = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] ins_i,
  input  logic        branch_cond_i,
  input  logic        mem_ack_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic        mem_is_fetch_o,
  output logic        ir_write_o,
  output logic        pc_write_o,
  output logic [1:0]  pc_sel_o,
  output logic [4:0]  imm_sel_o,
  output logic [1:0]  alu_src_a_o,
  output logic        alu_src_b_o,
  output logic [1:0]  alu_op_o,
  output logic        reg_write_o,
  output logic [1:0]  wb_sel_o,
  output logic        retire_o,
  output logic        trap_o,
  output logic [2:0]  state_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_e;

  // C_ILL is encoded as 0 so a reset class register reads as zero.
  typedef enum logic [3:0] {
    C_ILL    = 4'd0,
    C_OP     = 4'd1,
    C_OPIMM  = 4'd2,
    C_LOAD   = 4'd3,
    C_STORE  = 4'd4,
    C_BRANCH = 4'd5,
    C_JAL    = 4'd6,
    C_JALR   = 4'd7,
    C_LUI    = 4'd8,
    C_AUIPC  = 4'd9,
    C_NOP    = 4'd10
  } class_e;

  // Immediate format code: code N (1..5) lights imm_sel_o[N-1].
  localparam logic [2:0] IMM_NONE = 3'd0;
  localparam logic [2:0] IMM_UJ   = 3'd1;
  localparam logic [2:0] IMM_U    = 3'd2;
  localparam logic [2:0] IMM_SB   = 3'd3;
  localparam logic [2:0] IMM_S    = 3'd4;
  localparam logic [2:0] IMM_I    = 3'd5;

  state_e     state_q, state_d;
  class_e     class_q, class_d;
  class_e     dec_class;
  logic       timeout;
  logic [2:0] imm_code;
  logic       unused_ins;

  function automatic class_e classify(input logic [6:0] opc);
    class_e c;
    case (opc)
      7'b0110011: c = C_OP;
      7'b0010011: c = C_OPIMM;
      7'b0000011: c = C_LOAD;
      7'b0100011: c = C_STORE;
      7'b1100011: c = C_BRANCH;
      7'b1101111: c = C_JAL;
      7'b1100111: c = C_JALR;
      7'b0110111: c = C_LUI;
      7'b0010111: c = C_AUIPC;
      7'b0001111: c = C_NOP;   // FENCE
      7'b1110011: c = C_NOP;   // SYSTEM
      default:    c = C_ILL;   // also catches ins[1:0] != 2'b11
    endcase
    return c;
  endfunction

  function automatic logic [2:0] imm_of(input class_e c);
    logic [2:0] f;
    case (c)
      C_OPIMM, C_LOAD, C_JALR, C_NOP: f = IMM_I;
      C_STORE:                        f = IMM_S;
      C_BRANCH:                       f = IMM_SB;
      C_LUI, C_AUIPC:                 f = IMM_U;
      C_JAL:                          f = IMM_UJ;
      default:                        f = IMM_NONE;
    endcase
    return f;
  endfunction

  assign dec_class  = classify(ins_i[6:0]);
  // Only the opcode field steers control; the rest belongs to the datapath.
  assign unused_ins = ^ins_i[31:7];

`ifdef CTRL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;

  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

  // Counts unacknowledged request cycles; any ack or leaving FETCH/MEM
  // returns it to zero. timeout fires on the MEM_TIMEOUT-th silent cycle.
  always_comb begin
    cnt_d   = '0;
    timeout = 1'b0;
    if ((state_q == S_FETCH || state_q == S_MEM) && !mem_ack_i) begin
      if (MEM_TIMEOUT != 0 && cnt_q == TIMEOUT_W'(MEM_TIMEOUT - 1)) begin
        timeout = 1'b1;
      end else begin
        cnt_d = cnt_q + TIMEOUT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  localparam bit TRAP_EN = 1'b0;

  logic unused_cfg;

  assign timeout    = 1'b0;
  assign unused_cfg = (MEM_TIMEOUT != 0) ^ (TIMEOUT_W != 0);
`endif

  // Next-state and class capture.
  always_comb begin
    state_d = state_q;
    class_d = class_q;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ack_i)    state_d = S_DECODE;
        else if (timeout) state_d = S_TRAP;
      end
      S_DECODE: begin
        class_d = dec_class;
        state_d = (TRAP_EN && dec_class == C_ILL) ? S_TRAP : S_EXEC;
      end
      S_EXEC: begin
        case (class_q)
          C_OP, C_OPIMM, C_LUI, C_AUIPC: state_d = S_WB;
          C_LOAD, C_STORE:               state_d = S_MEM;
          default:                       state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (mem_ack_i)    state_d = (class_q == C_LOAD) ? S_WB : S_FETCH;
        else if (timeout) state_d = S_TRAP;
      end
      S_WB:    state_d = S_FETCH;
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      class_q <= C_ILL;
    end else begin
      state_q <= state_d;
      class_q <= class_d;
    end
  end

  // Output decode from the state and class registers. The ALU result is
  // expected to be captured by the datapath at the end of EXEC, so ALU
  // controls are only driven there.
  always_comb begin
    mem_req_o      = 1'b0;
    mem_we_o       = 1'b0;
    mem_is_fetch_o = 1'b0;
    ir_write_o     = 1'b0;
    pc_write_o     = 1'b0;
    pc_sel_o       = 2'd0;
    imm_code       = IMM_NONE;
    alu_src_a_o    = 2'd0;
    alu_src_b_o    = 1'b0;
    alu_op_o       = 2'd0;
    reg_write_o    = 1'b0;
    wb_sel_o       = 2'd0;
    retire_o       = 1'b0;
    trap_o         = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req_o      = 1'b1;
        mem_is_fetch_o = 1'b1;
        ir_write_o     = mem_ack_i;
      end
      S_DECODE: begin
        // Class is not registered yet; decode straight from the IR so the
        // immediate generator sees the format one cycle early.
        imm_code = imm_of(dec_class);
      end
      S_EXEC: begin
        imm_code = imm_of(class_q);
        case (class_q)
          C_OP: alu_op_o = 2'd1;
          C_OPIMM: begin
            alu_op_o    = 2'd1;
            alu_src_b_o = 1'b1;
          end
          C_LOAD, C_STORE: alu_src_b_o = 1'b1;
          C_BRANCH: begin
            alu_op_o   = 2'd2;
            pc_write_o = 1'b1;
            pc_sel_o   = branch_cond_i ? 2'd1 : 2'd0;
            retire_o   = 1'b1;
          end
          C_JAL: begin
            pc_write_o  = 1'b1;
            pc_sel_o    = 2'd1;
            reg_write_o = 1'b1;
            wb_sel_o    = 2'd2;
            retire_o    = 1'b1;
          end
          C_JALR: begin
            alu_src_b_o = 1'b1;
            pc_write_o  = 1'b1;
            pc_sel_o    = 2'd2;
            reg_write_o = 1'b1;
            wb_sel_o    = 2'd2;
            retire_o    = 1'b1;
          end
          C_LUI: begin
            alu_src_a_o = 2'd2;
            alu_src_b_o = 1'b1;
          end
          C_AUIPC: begin
            alu_src_a_o = 2'd1;
            alu_src_b_o = 1'b1;
          end
          default: begin
            // FENCE/SYSTEM, and illegal opcodes when trapping is disabled.
            pc_write_o = 1'b1;
            retire_o   = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        imm_code  = imm_of(class_q);
        mem_req_o = 1'b1;
        mem_we_o  = (class_q == C_STORE);
        if (class_q == C_STORE && mem_ack_i) begin
          pc_write_o = 1'b1;
          retire_o   = 1'b1;
        end
      end
      S_WB: begin
        imm_code    = imm_of(class_q);
        reg_write_o = 1'b1;
        wb_sel_o    = (class_q == C_LOAD) ? 2'd1 : 2'd0;
        pc_write_o  = 1'b1;
        retire_o    = 1'b1;
      end
      S_TRAP:  trap_o = TRAP_EN;
      default: ;
    endcase
  end

  for (genvar gi = 0; gi < 5; gi++) begin : g_imm_onehot
    assign imm_sel_o[gi] = (imm_code == 3'(gi + 1));
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed plus randomized bench for multicycle_ctrl. A per-opcode property
// table describes what each instruction class must do; every cycle the full
// output vector is compared against the expectation built from that table,
// and each instruction's fetch-to-retire latency is compared against the
// closed-form latency rule.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ins;
  logic        branch_cond;
  logic        mem_ack;
  logic        mem_req, mem_we, mem_is_fetch, ir_write, pc_write;
  logic [1:0]  pc_sel;
  logic [4:0]  imm_sel;
  logic [1:0]  alu_src_a;
  logic        alu_src_b;
  logic [1:0]  alu_op;
  logic        reg_write;
  logic [1:0]  wb_sel;
  logic        retire, trap;
  logic [2:0]  state;

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEM_TIMEOUT(4), .TIMEOUT_W(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .ins_i(ins), .branch_cond_i(branch_cond),
    .mem_ack_i(mem_ack), .mem_req_o(mem_req), .mem_we_o(mem_we),
    .mem_is_fetch_o(mem_is_fetch), .ir_write_o(ir_write), .pc_write_o(pc_write),
    .pc_sel_o(pc_sel), .imm_sel_o(imm_sel), .alu_src_a_o(alu_src_a),
    .alu_src_b_o(alu_src_b), .alu_op_o(alu_op), .reg_write_o(reg_write),
    .wb_sel_o(wb_sel), .retire_o(retire), .trap_o(trap), .state_o(state)
  );

  typedef struct packed {
    logic [2:0] state;
    logic       mem_req, mem_we, is_fetch, ir_write, pc_write;
    logic [1:0] pc_sel;
    logic [4:0] imm;
    logic [1:0] src_a;
    logic       src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       retire, trap;
  } outs_t;

  outs_t obs;
  assign obs = {state, mem_req, mem_we, mem_is_fetch, ir_write, pc_write, pc_sel,
                imm_sel, alu_src_a, alu_src_b, alu_op, reg_write, wb_sel, retire, trap};

  localparam int K_EXEC = 0, K_WB = 1, K_LOAD = 2, K_STORE = 3;
  localparam logic [4:0] F_I = 5'b10000, F_S = 5'b01000, F_SB = 5'b00100,
                         F_U = 5'b00010, F_UJ = 5'b00001, F_NONE = 5'b00000;
`ifdef CTRL_TRAP_EN
  localparam bit TB_TRAP = 1'b1;
`else
  localparam bit TB_TRAP = 1'b0;
`endif

  typedef struct {
    logic       illegal;
    int         kind;
    logic [4:0] imm;
    logic [1:0] a;
    logic       b;
    logic [1:0] op;
    logic [1:0] pcsel;
    logic       branch;
    logic       rw;
    logic [1:0] wb;
  } props_t;

  int checks = 0;
  int errors = 0;
  int cyc_in_instr;
  int lat_seen;

  function automatic props_t ref_props(input logic [31:0] i);
    props_t p;
    p = '{illegal: 1'b0, kind: K_EXEC, imm: F_NONE, a: 2'd0, b: 1'b0, op: 2'd0,
          pcsel: 2'd0, branch: 1'b0, rw: 1'b0, wb: 2'd0};
    case (i[6:0])
      7'h33: begin p.kind = K_WB; p.op = 2'd1; end
      7'h13: begin p.kind = K_WB; p.op = 2'd1; p.b = 1'b1; p.imm = F_I; end
      7'h03: begin p.kind = K_LOAD; p.b = 1'b1; p.imm = F_I; end
      7'h23: begin p.kind = K_STORE; p.b = 1'b1; p.imm = F_S; end
      7'h63: begin p.op = 2'd2; p.imm = F_SB; p.branch = 1'b1; end
      7'h6F: begin p.imm = F_UJ; p.pcsel = 2'd1; p.rw = 1'b1; p.wb = 2'd2; end
      7'h67: begin p.imm = F_I; p.b = 1'b1; p.pcsel = 2'd2; p.rw = 1'b1; p.wb = 2'd2; end
      7'h37: begin p.kind = K_WB; p.a = 2'd2; p.b = 1'b1; p.imm = F_U; end
      7'h17: begin p.kind = K_WB; p.a = 2'd1; p.b = 1'b1; p.imm = F_U; end
      7'h0F, 7'h73: p.imm = F_I;
      default: p.illegal = 1'b1;
    endcase
    return p;
  endfunction

  function automatic outs_t mk(input logic [2:0] s, input logic [4:0] imm);
    outs_t e;
    e = '0;
    e.state = s;
    e.imm = imm;
    return e;
  endfunction

  // One clock cycle: drive inputs 1 ns after the edge, compare 1 ns later.
  task automatic step(input logic r, input logic a, input logic b, input outs_t e,
                      input string tag);
    @(posedge clk);
    #1;
    rst_n = r;
    mem_ack = a;
    branch_cond = b;
    #1;
    cyc_in_instr++;
    if (obs.retire === 1'b1 && lat_seen < 0) lat_seen = cyc_in_instr;
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, e);
    end
  endtask

  // Caller has already driven rst_n low in the preceding cycle.
  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'($urandom_range(1, 0)), 1'b0, '0, "reset");
    // Release: this cycle is still IDLE and must ignore a stray ack.
    step(1'b1, 1'b1, 1'b0, '0, "idle");
  endtask

  function automatic logic noise();
    return 1'($urandom_range(1, 0));
  endfunction

  task automatic run_instr(input logic [31:0] i, input int fw, input int mw,
                           input logic bc, input bit abort, input string tag);
    props_t p;
    outs_t  e;
    int     lat_exp;
    bit     last;
    p = ref_props(i);
    ins = i;
    cyc_in_instr = 0;
    lat_seen = -1;
    for (int k = 0; k <= fw; k++) begin
      last = (k == fw);
      e = mk(3'd1, F_NONE);
      e.mem_req = 1'b1;
      e.is_fetch = 1'b1;
      e.ir_write = last;
      step(1'b1, last, noise(), e, {tag, "/fetch"});
    end
    step(1'b1, noise(), noise(), mk(3'd2, p.imm), {tag, "/decode"});
    e = mk(3'd3, p.imm);
    e.src_a = p.a;
    e.src_b = p.b;
    e.alu_op = p.op;
    if (p.kind == K_EXEC) begin
      e.pc_write = 1'b1;
      e.pc_sel = p.branch ? {1'b0, bc} : p.pcsel;
      e.reg_write = p.rw;
      e.wb_sel = p.wb;
      e.retire = 1'b1;
    end
    step(1'b1, noise(), bc, e, {tag, "/exec"});
    if (p.kind == K_LOAD || p.kind == K_STORE) begin
      for (int k = 0; k <= mw; k++) begin
        last = (k == mw);
        e = mk(3'd4, p.imm);
        e.mem_req = 1'b1;
        e.mem_we = (p.kind == K_STORE);
        if (last && !abort && p.kind == K_STORE) begin
          e.pc_write = 1'b1;
          e.retire = 1'b1;
        end
        step(!(last && abort), last && !abort, noise(), e, {tag, "/mem"});
      end
      if (abort) return;
    end
    if (p.kind == K_WB || p.kind == K_LOAD) begin
      e = mk(3'd5, p.imm);
      e.reg_write = 1'b1;
      e.wb_sel = (p.kind == K_LOAD) ? 2'd1 : 2'd0;
      e.pc_write = 1'b1;
      e.retire = 1'b1;
      step(1'b1, noise(), noise(), e, {tag, "/wb"});
    end
    case (p.kind)
      K_EXEC:  lat_exp = 3 + fw;
      K_WB:    lat_exp = 4 + fw;
      K_STORE: lat_exp = 4 + fw + mw;
      default: lat_exp = 5 + fw + mw;
    endcase
    checks++;
    assert (lat_seen === lat_exp) else begin
      errors++;
      $error("FAIL %s/latency: observed=%0d expected=%0d", tag, lat_seen, lat_exp);
    end
  endtask

`ifdef CTRL_TRAP_EN
  // Hold in TRAP for a few cycles, then assert reset on the last one.
  task automatic hold_trap(input string tag);
    outs_t e;
    e = mk(3'd6, F_NONE);
    e.trap = 1'b1;
    for (int k = 0; k < 4; k++) step(k < 3, noise(), noise(), e, tag);
    do_reset(1);
  endtask
`endif

  logic [6:0]  opcs [12];
  logic [31:0] rnd;
  int          nopc;

  initial begin
    outs_t e;
    rst_n = 1'b0;
    mem_ack = 1'b0;
    branch_cond = 1'b0;
    ins = 32'h0;
    opcs = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17,
             7'h0F, 7'h73, 7'h7F};

    do_reset(3);
    run_instr(32'h00500093, 0, 0, 1'b0, 1'b0, "addi");
    run_instr(32'h0040A103, 2, 3, 1'b0, 1'b0, "lw");
    run_instr(32'hFE000EE3, 0, 0, 1'b1, 1'b0, "beq_taken");
    run_instr(32'hFE000EE3, 0, 0, 1'b0, 1'b0, "beq_not");
    run_instr(32'h008000EF, 0, 0, 1'b0, 1'b0, "jal");
    run_instr(32'h00812023, 1, 2, 1'b0, 1'b0, "sw");
    run_instr(32'h00812023, 0, 0, 1'b0, 1'b0, "sw_fast");
    run_instr(32'h000080E7, 0, 0, 1'b0, 1'b0, "jalr");
    run_instr(32'h123450B7, 0, 0, 1'b0, 1'b0, "lui");
    run_instr(32'h00001097, 1, 0, 1'b0, 1'b0, "auipc");
    run_instr(32'h002081B3, 0, 0, 1'b0, 1'b0, "add");
    run_instr(32'h0000000F, 0, 0, 1'b0, 1'b0, "fence");
    run_instr(32'h00000073, 0, 0, 1'b0, 1'b0, "ecall");

`ifdef CTRL_TRAP_EN
    // Illegal opcode traps from DECODE.
    ins = 32'h0000007F;
    e = mk(3'd1, F_NONE);
    e.mem_req = 1'b1;
    e.is_fetch = 1'b1;
    e.ir_write = 1'b1;
    step(1'b1, 1'b1, 1'b0, e, "ill/fetch");
    step(1'b1, 1'b0, 1'b0, mk(3'd2, F_NONE), "ill/decode");
    hold_trap("ill/trap");
    // Fetch never acknowledged: four silent FETCH cycles, then TRAP.
    e = mk(3'd1, F_NONE);
    e.mem_req = 1'b1;
    e.is_fetch = 1'b1;
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 1'b0, e, "fetch_to/fetch");
    hold_trap("fetch_to/trap");
    // Load data never acknowledged: four silent MEM cycles, then TRAP.
    ins = 32'h0040A103;
    e = mk(3'd1, F_NONE);
    e.mem_req = 1'b1;
    e.is_fetch = 1'b1;
    e.ir_write = 1'b1;
    step(1'b1, 1'b1, 1'b0, e, "mem_to/fetch");
    step(1'b1, 1'b0, 1'b0, mk(3'd2, F_I), "mem_to/decode");
    e = mk(3'd3, F_I);
    e.src_b = 1'b1;
    step(1'b1, 1'b0, 1'b0, e, "mem_to/exec");
    e = mk(3'd4, F_I);
    e.mem_req = 1'b1;
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 1'b0, e, "mem_to/mem");
    hold_trap("mem_to/trap");
`else
    run_instr(32'h0000007F, 0, 0, 1'b0, 1'b0, "ill_7f");
    run_instr(32'h00000012, 1, 0, 1'b0, 1'b0, "ill_lowbits");
`endif

    // Randomized instruction stream.
    nopc = TB_TRAP ? 11 : 12;
    for (int n = 0; n < 60; n++) begin
      rnd = $urandom();
      run_instr({rnd[31:7], opcs[$urandom_range(nopc - 1, 0)]},
                $urandom_range(2, 0), $urandom_range(2, 0), 1'($urandom_range(1, 0)),
                1'b0, "rand");
    end

    // Reset in the middle of a load's MEM wait: IDLE with MemReq low next cycle.
    run_instr(32'h0040A103, 0, 1, 1'b0, 1'b1, "lw_rst");
    do_reset(1);
    run_instr(32'h00500093, 0, 0, 1'b0, 1'b0, "addi_after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

- Multi-cycle control FSM for the RISC-V core; one instruction in flight.
- Sequences fetch, decode, execute, memory and writeback, and drives every datapath enable and mux select.
- Drives the one-hot format select consumed by the immediate generator.
- Sits between the memory port, the instruction register, the PC, ALU, register file and immediate generator.

## Interface
- MEM_TIMEOUT, 255: cycles MemReq may stay unacknowledged before trapping (only with CTRL_TRAP_EN). 0 disables the check.
- TIMEOUT_W, 8: width of the timeout counter. MEM_TIMEOUT must be < 2^TIMEOUT_W.
- Clk  in  1  sole clock, rising edge.
- Rst_n  in  1  synchronous, active-low reset.
- Ins  in  32  instruction register contents; stable from IrWrite until the next FETCH.
- BranchCond  in  1  ALU compare result, valid in EXEC.
- MemAck  in  1  memory completion pulse; may coincide with the first MemReq cycle.
- MemReq  out  1  memory request.
- MemWe  out  1  store request.
- MemIsFetch  out  1  address select: 1 = PC, 0 = ALU result.
- IrWrite  out  1  load instruction register.
- PcWrite  out  1  update PC.
- PcSel  out  2  0 = PC+4, 1 = PC+imm, 2 = {ALU[31:1],1'b0}.
- ImmSel  out  5  one-hot format: 10000 I, 01000 S, 00100 SB, 00010 U, 00001 UJ, 00000 R/none.
- AluSrcA  out  2  0 = rs1, 1 = PC, 2 = zero.
- AluSrcB  out  1  0 = rs2, 1 = imm.
- AluOp  out  2  0 = add, 1 = funct-decoded, 2 = branch compare.
- RegWrite  out  1  register file write.
- WbSel  out  2  0 = ALU, 1 = load data, 2 = PC+4.
- Retire  out  1  one-cycle pulse per completed instruction.
- Trap  out  1  sticky fault flag.
- State  out  3  current state, debug.

## Operation
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6.
- IDLE: reset state, all outputs 0; goes unconditionally to FETCH.
- FETCH: MemReq=1, MemIsFetch=1. Stay until MemAck. On the MemAck cycle: IrWrite=1, next state DECODE.
- DECODE (1 cycle): classify Ins[6:0] into a registered class; ImmSel valid from DECODE through retire.
- Class actions, written as EXEC / MEM / WB; PcWrite with PcSel=0 happens in the retire cycle unless stated otherwise:
  - OP 0110011: EXEC AluOp=1 / - / WB RegWrite, WbSel=0.
  - OP-IMM 0010011: as OP, but AluSrcB=1, ImmSel I.
  - LOAD 0000011: EXEC add rs1+imm / MEM MemReq until MemAck / WB WbSel=1.
  - STORE 0100011: EXEC add, ImmSel S / MEM MemWe=1 / retire on the MemAck cycle.
  - BRANCH 1100011: EXEC AluOp=2, ImmSel SB, PcWrite, PcSel=BranchCond?1:0; retire in EXEC.
  - JAL 1101111: EXEC PcSel=1, RegWrite, WbSel=2, ImmSel UJ; retire in EXEC.
  - JALR 1100111: EXEC add rs1+imm, PcSel=2, RegWrite, WbSel=2, ImmSel I; retire in EXEC.
  - LUI 0110111: AluSrcA=2, AluSrcB=1, ImmSel U → WB.
  - AUIPC 0010111: AluSrcA=1, AluSrcB=1, ImmSel U → WB.
  - FENCE 0001111 and SYSTEM 1110011: NOP, ImmSel I; retire in EXEC.
- Illegal: any other opcode, or Ins[1:0]≠11.
- Retire: the cycle that retires also pulses Retire and does PcWrite; next state FETCH.
- MemAck in any state without MemReq is ignored.
- Outputs are combinational from the state and class registers; IrWrite, and PcWrite/Retire in MEM, also depend on MemAck.

## Timing
- Minimum latencies with zero-wait memory (MemAck in the first request cycle):
  - BRANCH/JAL/JALR/NOP: 3 cycles.
  - OP/OP-IMM/LUI/AUIPC/STORE: 4 cycles.
  - LOAD: 5 cycles.
- Each memory wait cycle adds 1 cycle.
- Reset: Rst_n sampled low at a rising edge puts the FSM in IDLE and clears the counter, class register and all outputs to 0. This applies mid-instruction too; an outstanding MemReq drops the cycle after that edge.
- First FETCH request: the 2nd cycle after Rst_n is sampled high.

## Configuration
- CTRL_TRAP_EN defined:
  - An illegal opcode in DECODE goes to TRAP.
  - A timeout counter runs while MemReq=1 in FETCH/MEM and clears on MemAck or state exit. When it reaches MEM_TIMEOUT with no ack, next state is TRAP.
  - TRAP: Trap=1, all other outputs 0, held until reset.
- CTRL_TRAP_EN undefined:
  - No TRAP state and no counter; Trap is tied 0 and MEM_TIMEOUT is ignored.
  - Illegal opcodes retire as NOP in EXEC with PC+4.

## Test plan
- Reset, then Ins=0x00500093 (addi) with immediate MemAck → State 1,2,3,5; ImmSel=10000; AluSrcB=1; RegWrite and Retire in cycle 4.
- lw 0x0040A103 with fetch ack delay 2 and load ack delay 3 → 10 cycles fetch to Retire; WbSel=1 in WB.
- beq 0xFE000EE3 with BranchCond=1, then =0 → EXEC PcSel=1, then 0; ImmSel=00100; Retire after 3 cycles.
- jal 0x008000EF → EXEC PcSel=1, RegWrite=1, WbSel=2, ImmSel=00001 in the same cycle.
- Ins=0x0000007F: with CTRL_TRAP_EN Trap=1 held; without it Retire, PcSel=0, back to FETCH.
- With CTRL_TRAP_EN, MEM_TIMEOUT=4, MemAck never asserted → TRAP after 4 FETCH cycles. Rst_n low mid-MEM → IDLE next cycle, MemReq=0.
